// File: rtl/regfile_mp.sv
// Multi-port CPU register file: NRD registered read ports, two write ports with
// write-through bypass, and an integrated program counter at register PC_IDX.
module regfile_mp #(
  parameter int              DW       = 32,
  parameter int              AW       = 4,
  parameter int              NRD      = 3,
  parameter int              PC_IDX   = 2**AW-1,
  parameter int              PC_INC   = 4,
  parameter int              PC_RDOFS = 8,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              ib,
  input  logic [DW-1:0]     bv,
  output logic [DW-1:0]     iaddrout
);

  localparam int unsigned   NREG = 2**AW;
  localparam int unsigned   NRP  = NRD;
  localparam logic [AW-1:0] PCA  = AW'(PC_IDX);

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] pc, pc_next, pc_rd;
  logic [DW-1:0] rd_next [NRD];
  logic [DW-1:0] rd_q    [NRD];
  logic          w0, w1;

  // Writes aimed at the PC index go to the PC logic, never to the array.
  assign w0    = we0 && (wa0 != PCA);
  assign w1    = we1 && (wa1 != PCA);
  assign pc_rd = pc + DW'(PC_RDOFS);

  always_comb begin
    for (int unsigned k = 0; k < NRP; k++) begin
      rd_next[k] = regs[raddr[k*AW +: AW]];
      if (raddr[k*AW +: AW] == PCA)
        rd_next[k] = pc_rd;
      else if (w1 && (wa1 == raddr[k*AW +: AW]))
        rd_next[k] = wd1;
      else if (w0 && (wa0 == raddr[k*AW +: AW]))
        rd_next[k] = wd0;
    end
  end

  always_comb begin
    pc_next = pc + DW'(PC_INC);
    if (ib)
      pc_next = bv;
    else if (we1 && (wa1 == PCA))
      pc_next = wd1;
    else if (we0 && (wa0 == PCA))
      pc_next = wd0;
  end

  // Port 1 is assigned last so it wins when both ports target one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (en) begin
      if (w0) regs[wa0] <= wd0;
      if (w1) regs[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int unsigned k = 0; k < NRP; k++)
        rd_q[k] <= '0;
    end else if (en) begin
      pc <= pc_next;
      for (int unsigned k = 0; k < NRP; k++)
        rd_q[k] <= rd_next[k];
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g*DW +: DW] = rd_q[g];
  end

  assign iaddrout = pc;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected read data and PC,
// a monitor pops and compares one edge later.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NRD = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              we0, we1, ib;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1, bv;
  logic [DW-1:0]     iaddrout;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .en(en), .raddr(raddr), .rdata(rdata),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ib(ib), .bv(bv), .iaddrout(iaddrout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NRD*DW-1:0] rd;
    logic [DW-1:0]     pc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference state: architectural registers, PC and last read results.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mpc;
  logic [DW-1:0] mrd [NRD];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int k = 0; k < NRD; k++) mrd[k] = '0;
    mpc = '0;
  endtask

  task automatic idle();
    en = 1'b1; we0 = 1'b0; we1 = 1'b0; ib = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; bv = '0;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  // Applies the architectural rules for one edge, queues the result, then
  // advances to the next falling edge.
  task automatic tick();
    logic [DW-1:0] nmem [16];
    logic [AW-1:0] ra;
    exp_t e;
    nmem = mem;
    if (en) begin
      if (we0 && wa0 != 4'hF) nmem[wa0] = wd0;
      if (we1 && wa1 != 4'hF) nmem[wa1] = wd1;
      for (int k = 0; k < NRD; k++) begin
        ra = raddr[k*AW +: AW];
        mrd[k] = (ra == 4'hF) ? mpc + 32'd8 : nmem[ra];
      end
      if (ib)                       mpc = bv;
      else if (we1 && wa1 == 4'hF)  mpc = wd1;
      else if (we0 && wa0 == 4'hF)  mpc = wd0;
      else                          mpc = mpc + 32'd4;
      mem = nmem;
    end
    for (int k = 0; k < NRD; k++) e.rd[k*DW +: DW] = mrd[k];
    e.pc = mpc;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("iaddrout", iaddrout, e.pc);
        for (int k = 0; k < NRD; k++)
          chk($sformatf("rdata%0d", k), rdata[k*DW +: DW], e.rd[k*DW +: DW]);
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    raddr = '0;
    idle();
    model_reset();
    #1;
    chk("reset_pc", iaddrout, 32'h0);
    chk("reset_rdata", rdata[31:0] | rdata[63:32] | rdata[95:64], 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fill a few registers and move the PC to 0x40.
    for (int i = 0; i < 4; i++) begin
      idle(); we0 = 1'b1; wa0 = AW'(i + 1); wd0 = 32'hA000_0000 + i;
      set_ra(0, AW'(i)); tick();
    end
    idle(); ib = 1'b1; bv = 32'h40; set_ra(0, 4'd1); set_ra(1, 4'd2); tick();

    // T1: asynchronous reset mid-run.
    idle();
    reset = 1'b1;
    #1;
    model_reset();
    chk("t1_async_pc", iaddrout, 32'h0);
    for (int k = 0; k < NRD; k++) chk("t1_async_rd", rdata[k*DW +: DW], 32'h0);
    repeat (2) @(negedge clk);
    chk("t1_hold_pc", iaddrout, 32'h0);
    reset = 1'b0;
    raddr = '0;
    tick(); tick(); tick();

    // T2: write then read.
    idle(); we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEADBEEF; tick();
    idle(); set_ra(0, 4'd3); tick();

    // T3: bypass, then both ports on the same register.
    idle(); we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11; set_ra(1, 4'd5); tick();
    idle(); we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22; set_ra(1, 4'd5); tick();
    idle(); set_ra(0, 4'd5); set_ra(1, 4'd0); tick();

    // T4: PC write priority.
    idle(); ib = 1'b1; bv = 32'h100; we1 = 1'b1; wa1 = 4'hF; wd1 = 32'h200; tick();
    idle(); we0 = 1'b1; wa0 = 4'hF; wd0 = 32'h300; tick();
    idle(); we1 = 1'b1; wa1 = 4'hF; wd1 = 32'h500; we0 = 1'b1; wa0 = 4'hF; wd0 = 32'h600; tick();
    idle(); tick();

    // T5: PC read offset and wrap.
    idle(); ib = 1'b1; bv = 32'h20; tick();
    idle(); set_ra(2, 4'hF); tick();
    idle(); ib = 1'b1; bv = 32'hFFFF_FFFC; set_ra(2, 4'd0); tick();
    idle(); set_ra(2, 4'hF); tick();
    idle(); tick();

    // T6: stall drops writes and branches.
    for (int i = 0; i < 3; i++) begin
      idle(); en = 1'b0; we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h1234_0000 + i;
      ib = 1'b1; bv = 32'h800; raddr = 12'($urandom); tick();
    end
    idle(); set_ra(0, 4'd3); set_ra(1, 4'd5); set_ra(2, 4'hF); tick();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      en  = ($urandom_range(0, 9) != 0);
      we0 = $urandom_range(0, 1) == 1;
      we1 = $urandom_range(0, 1) == 1;
      wa0 = 4'($urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      ib  = ($urandom_range(0, 7) == 0);
      bv  = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      for (int k = 0; k < NRD; k++)
        set_ra(k, ($urandom_range(0, 4) == 0) ? wa0 : 4'($urandom));
      tick();
    end

    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
